ctrlport_window_router: RTL and testbench
=========================================

Name: ctrlport_window_router

Overview:
- Parametrised successor to the fixed 4-way core ctrlport fan-out: routes one ctrlport master to NUM_SLAVES address windows, each with a configurable base and power-of-two size.
- Adds what the broadcast splitter lacks: true address decode, optional base-relative addressing, an error response for unmapped addresses, a response timeout, and saturating error counters.
- Sits in the rfnoc_ctrl_clk domain between the ctrlport clock crossing and the mboard register endpoints (global regs, versioning, timekeeper, DIO, future windows).

Parameters:
- NUM_SLAVES, 4, number of downstream windows (1..16).
- BASE_ADDR, {20'h2000,20'h1000,20'h00C00,20'h00000}, packed 20-bit window bases; slave i uses [20*i+:20].
- WINDOW_LOG2, {5'd5,5'd5,5'd10,5'd11}, packed 5-bit log2 window sizes; slave i uses [5*i+:5]. Each base must be aligned to its size; the simulation model raises $error at elaboration if not.
- RELATIVE_ADDR, 0, 1 = subtract the window base from the address forwarded to the slave; 0 = forward the full address.
- TIMEOUT, 1023, response wait limit in cycles; 0 disables the timeout.

Ports:
- ctrlport_clk  in  1  sole clock.
- ctrlport_rst  in  1  synchronous, active-high reset.
- s_ctrlport_req_wr  in  1  write request strobe.
- s_ctrlport_req_rd  in  1  read request strobe.
- s_ctrlport_req_addr  in  20  byte address.
- s_ctrlport_req_data  in  32  write data.
- s_ctrlport_req_byte_en  in  4  byte enables.
- s_ctrlport_resp_ack  out  1  response strobe.
- s_ctrlport_resp_status  out  2  0=OKAY, 1=CMDERR, 2=TSERR, 3=WARNING.
- s_ctrlport_resp_data  out  32  read data.
- m_ctrlport_req_wr  out  NUM_SLAVES  per-slave write strobe.
- m_ctrlport_req_rd  out  NUM_SLAVES  per-slave read strobe.
- m_ctrlport_req_addr  out  20*NUM_SLAVES  per-slave address.
- m_ctrlport_req_data  out  32*NUM_SLAVES  per-slave write data.
- m_ctrlport_req_byte_en  out  4*NUM_SLAVES  per-slave byte enables.
- m_ctrlport_resp_ack  in  NUM_SLAVES  per-slave ack.
- m_ctrlport_resp_status  in  2*NUM_SLAVES  per-slave status.
- m_ctrlport_resp_data  in  32*NUM_SLAVES  per-slave data.
- unmapped_count  out  16  saturating count of unmapped or malformed requests.
- timeout_count  out  16  saturating count of timeouts.

Behaviour:
- Reset: all outputs 0; state IDLE; both counters 0. A reset in any state aborts the transaction with no ack emitted. Requests asserted during reset are ignored.
- Decode: slave i hits when (addr >> WINDOW_LOG2[i]) == (BASE_ADDR[i] >> WINDOW_LOG2[i]). On overlapping windows, the lowest index wins.
- State machine: IDLE, WAIT, ERR.
- IDLE, request wr XOR rd with a hit on slave i:
  - Register the request. On the next cycle, drive exactly one cycle of m_req_wr[i] / m_req_rd[i], with that slave's addr/data/byte_en fields. Other slaves' strobes stay 0; their fields may hold stale data.
  - Forwarded address = addr - BASE_ADDR[i] if RELATIVE_ADDR, else addr.
  - Capture sel=i, clear the timer, go to WAIT.
- IDLE, request with no hit, or wr and rd both high: go to ERR.
- ERR: emit s_resp_ack=1, status=1 (CMDERR), data=0. The ack lands 1 cycle after the request. Increment unmapped_count, return to IDLE.
- WAIT:
  - Only m_resp_ack[sel] is observed; acks from other slaves are ignored.
  - On m_resp_ack[sel], register status[sel] and data[sel] to the s_resp outputs with a 1-cycle ack pulse (1 cycle after the slave ack), then return to IDLE.
  - The timer increments each cycle in WAIT. If TIMEOUT != 0 and the timer reaches TIMEOUT with no ack, emit an ack with status=1, data=0, increment timeout_count, and go to IDLE.
  - If the ack and timeout expiry occur in the same cycle, the ack wins: slave response, no count.
- Slave acks arriving after a timeout (in IDLE) are discarded.
- Busy: a new request arriving in WAIT or ERR is dropped (no forward, no ack). Masters are required to hold one outstanding transaction.
- End-to-end latency for a mapped access with a slave ack in the same cycle as its request: 3 cycles from s_req to s_resp_ack.
- Counters saturate at 16'hFFFF.

Test Plan:
- Read addr 20'h0C04, slave 1 acks 2 cycles after its strobe with data 32'hCAFE0001, status 0 -> m_req_rd = 4'b0010 for 1 cycle with addr 20'h0C04; s_resp_ack 1 cycle after the slave ack with data 32'hCAFE0001, status 0.
- RELATIVE_ADDR=1, write addr 20'h2010, data 32'h5A -> slave 3 receives addr 20'h0010, data 32'h5A, byte_en 4'hF; others see no strobe.
- Read addr 20'h3000 (unmapped) -> s_resp_ack exactly 1 cycle later, status 1, data 0; unmapped_count 0->1; no m strobes.
- TIMEOUT=8, slave 0 never acks -> ack with status 1 at the 8th WAIT cycle; timeout_count 1; a slave-0 ack injected afterwards produces no s_resp_ack.
- Slave 2 ack in the same cycle the timer reaches TIMEOUT -> slave data/status returned, timeout_count unchanged. Separately, wr and rd both high -> CMDERR response.
- Reset asserted mid-WAIT, then slave acks -> no s_resp_ack; next request is handled normally. Force 65536 unmapped requests -> unmapped_count holds at 16'hFFFF.

Source files
------------

// File: rtl/ctrlport_window_router.sv
// ctrlport_window_router: routes one ctrlport master to NUM_SLAVES address
// windows (base + power-of-two size). Unmapped or malformed requests get a
// CMDERR response. Slave responses are bounded by a timeout. Saturating
// counters track both kinds of error.
//
// Ports:
//   ctrlport_clk / ctrlport_rst      clock, synchronous active-high reset
//   s_ctrlport_req_*                 upstream request (wr, rd, addr, data, byte_en)
//   s_ctrlport_resp_*                upstream response (ack, status, data)
//   m_ctrlport_req_*                 per-slave request buses, slave i in slice i
//   m_ctrlport_resp_*                per-slave response buses, slave i in slice i
//   unmapped_count                   saturating count of unmapped/malformed requests
//   timeout_count                    saturating count of response timeouts
module ctrlport_window_router #(
   parameter int unsigned                   NUM_SLAVES    = 4,
   parameter logic [20*NUM_SLAVES-1:0]      BASE_ADDR     = {20'h02000, 20'h01000, 20'h00C00, 20'h00000},
   parameter logic [5*NUM_SLAVES-1:0]       WINDOW_LOG2   = {5'd5, 5'd5, 5'd10, 5'd11},
   parameter bit                            RELATIVE_ADDR = 1'b0,
   parameter int unsigned                   TIMEOUT       = 1023
) (
   input  logic                      ctrlport_clk,
   input  logic                      ctrlport_rst,
   input  logic                      s_ctrlport_req_wr,
   input  logic                      s_ctrlport_req_rd,
   input  logic [19:0]               s_ctrlport_req_addr,
   input  logic [31:0]               s_ctrlport_req_data,
   input  logic [3:0]                s_ctrlport_req_byte_en,
   output logic                      s_ctrlport_resp_ack,
   output logic [1:0]                s_ctrlport_resp_status,
   output logic [31:0]               s_ctrlport_resp_data,
   output logic [NUM_SLAVES-1:0]     m_ctrlport_req_wr,
   output logic [NUM_SLAVES-1:0]     m_ctrlport_req_rd,
   output logic [20*NUM_SLAVES-1:0]  m_ctrlport_req_addr,
   output logic [32*NUM_SLAVES-1:0]  m_ctrlport_req_data,
   output logic [4*NUM_SLAVES-1:0]   m_ctrlport_req_byte_en,
   input  logic [NUM_SLAVES-1:0]     m_ctrlport_resp_ack,
   input  logic [2*NUM_SLAVES-1:0]   m_ctrlport_resp_status,
   input  logic [32*NUM_SLAVES-1:0]  m_ctrlport_resp_data,
   output logic [15:0]               unmapped_count,
   output logic [15:0]               timeout_count
);

   localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          TMO_EN = (TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [1:0]  ST_CMDERR = 2'd1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

   // Elaboration-time check that every window base is aligned to its size
   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_align
      if (((BASE_ADDR[20*g +: 20] >> WINDOW_LOG2[5*g +: 5]) << WINDOW_LOG2[5*g +: 5])
          != BASE_ADDR[20*g +: 20]) begin : g_err
         $error("ctrlport_window_router: window %0d base not aligned to its size", g);
      end
   end

   state_t                    state_q, state_d;
   logic                      req_wr_q, req_wr_d;
   logic [19:0]               req_addr_q, req_addr_d;
   logic [31:0]               req_data_q, req_data_d;
   logic [3:0]                req_be_q, req_be_d;
   logic [IDX_W-1:0]          sel_q, sel_d;
   logic                      issue_q, issue_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic                      resp_ack_q, resp_ack_d;
   logic [1:0]                resp_status_q, resp_status_d;
   logic [31:0]               resp_data_q, resp_data_d;
   logic [NUM_SLAVES-1:0]     m_wr_q, m_wr_d, m_rd_q, m_rd_d;
   logic [20*NUM_SLAVES-1:0]  m_addr_q, m_addr_d;
   logic [32*NUM_SLAVES-1:0]  m_data_q, m_data_d;
   logic [4*NUM_SLAVES-1:0]   m_be_q, m_be_d;
   logic [15:0]               unmapped_q, unmapped_d;
   logic [15:0]               timeout_q, timeout_d;

   logic                      hit;
   logic [IDX_W-1:0]          hit_idx;
   logic                      req_any, req_ok, sel_ack, timed_out;
   logic [19:0]               fwd_addr;

   // Window decode; scanning downward leaves the lowest matching index
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
         if ((s_ctrlport_req_addr >> WINDOW_LOG2[5*i +: 5]) ==
             (BASE_ADDR[20*i +: 20] >> WINDOW_LOG2[5*i +: 5])) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign req_any   = s_ctrlport_req_wr | s_ctrlport_req_rd;
   assign req_ok    = hit & (s_ctrlport_req_wr ^ s_ctrlport_req_rd);
   assign sel_ack   = m_ctrlport_resp_ack[sel_q];
   assign timed_out = TMO_EN && (timer_q == TMO_LAST);
   assign fwd_addr  = RELATIVE_ADDR ? (s_ctrlport_req_addr - BASE_ADDR[20*hit_idx +: 20])
                                    : s_ctrlport_req_addr;

   // State register
   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_any) state_d = req_ok ? ST_WAIT : ST_ERR;
         ST_WAIT: if (sel_ack || timed_out) state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      req_wr_d      = req_wr_q;
      req_addr_d    = req_addr_q;
      req_data_d    = req_data_q;
      req_be_d      = req_be_q;
      sel_d         = sel_q;
      issue_d       = 1'b0;
      timer_d       = timer_q;
      resp_ack_d    = 1'b0;
      resp_status_d = resp_status_q;
      resp_data_d   = resp_data_q;
      m_wr_d        = '0;
      m_rd_d        = '0;
      m_addr_d      = m_addr_q;
      m_data_d      = m_data_q;
      m_be_d        = m_be_q;
      unmapped_d    = unmapped_q;
      timeout_d     = timeout_q;

      // Captured request goes out to the selected slave one cycle later
      if (issue_q) begin
         m_wr_d[sel_q]              = req_wr_q;
         m_rd_d[sel_q]              = ~req_wr_q;
         m_addr_d[20*sel_q +: 20]   = req_addr_q;
         m_data_d[32*sel_q +: 32]   = req_data_q;
         m_be_d[4*sel_q +: 4]       = req_be_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               if (req_ok) begin
                  req_wr_d   = s_ctrlport_req_wr;
                  req_addr_d = fwd_addr;
                  req_data_d = s_ctrlport_req_data;
                  req_be_d   = s_ctrlport_req_byte_en;
                  sel_d      = hit_idx;
                  issue_d    = 1'b1;
                  timer_d    = '0;
               end else begin
                  // Ack is registered here so it is visible during ERR
                  resp_ack_d    = 1'b1;
                  resp_status_d = ST_CMDERR;
                  resp_data_d   = '0;
               end
            end
         end
         ST_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (sel_ack) begin
               resp_ack_d    = 1'b1;
               resp_status_d = m_ctrlport_resp_status[2*sel_q +: 2];
               resp_data_d   = m_ctrlport_resp_data[32*sel_q +: 32];
            end else if (timed_out) begin
               resp_ack_d    = 1'b1;
               resp_status_d = ST_CMDERR;
               resp_data_d   = '0;
               timeout_d     = (timeout_q == 16'hFFFF) ? timeout_q : timeout_q + 16'd1;
            end
         end
         ST_ERR: begin
            unmapped_d = (unmapped_q == 16'hFFFF) ? unmapped_q : unmapped_q + 16'd1;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst) begin
         req_wr_q      <= 1'b0;
         req_addr_q    <= '0;
         req_data_q    <= '0;
         req_be_q      <= '0;
         sel_q         <= '0;
         issue_q       <= 1'b0;
         timer_q       <= '0;
         resp_ack_q    <= 1'b0;
         resp_status_q <= '0;
         resp_data_q   <= '0;
         m_wr_q        <= '0;
         m_rd_q        <= '0;
         m_addr_q      <= '0;
         m_data_q      <= '0;
         m_be_q        <= '0;
         unmapped_q    <= '0;
         timeout_q     <= '0;
      end else begin
         req_wr_q      <= req_wr_d;
         req_addr_q    <= req_addr_d;
         req_data_q    <= req_data_d;
         req_be_q      <= req_be_d;
         sel_q         <= sel_d;
         issue_q       <= issue_d;
         timer_q       <= timer_d;
         resp_ack_q    <= resp_ack_d;
         resp_status_q <= resp_status_d;
         resp_data_q   <= resp_data_d;
         m_wr_q        <= m_wr_d;
         m_rd_q        <= m_rd_d;
         m_addr_q      <= m_addr_d;
         m_data_q      <= m_data_d;
         m_be_q        <= m_be_d;
         unmapped_q    <= unmapped_d;
         timeout_q     <= timeout_d;
      end
   end

   assign s_ctrlport_resp_ack    = resp_ack_q;
   assign s_ctrlport_resp_status = resp_status_q;
   assign s_ctrlport_resp_data   = resp_data_q;
   assign m_ctrlport_req_wr      = m_wr_q;
   assign m_ctrlport_req_rd      = m_rd_q;
   assign m_ctrlport_req_addr    = m_addr_q;
   assign m_ctrlport_req_data    = m_data_q;
   assign m_ctrlport_req_byte_en = m_be_q;
   assign unmapped_count         = unmapped_q;
   assign timeout_count          = timeout_q;

endmodule

// File: tb/tb_ctrlport_window_router.sv
// Testbench for ctrlport_window_router. Two instances share all stimulus:
// one forwards absolute addresses, the other base-relative addresses. Both
// use an 8-cycle timeout. Expected responses are queued when stimulus is
// driven and popped whenever an upstream ack appears.
module tb_ctrlport_window_router;

   localparam int unsigned NS  = 4;
   localparam int unsigned TMO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              req_wr, req_rd;
   logic [19:0]       req_addr;
   logic [31:0]       req_data;
   logic [3:0]        req_be;
   logic [NS-1:0]     sl_ack;
   logic [2*NS-1:0]   sl_status;
   logic [32*NS-1:0]  sl_data;

   logic              a_ack, r_ack;
   logic [1:0]        a_status, r_status;
   logic [31:0]       a_data, r_data;
   logic [NS-1:0]     a_wr, a_rd, r_wr, r_rd;
   logic [20*NS-1:0]  a_addr, r_addr;
   logic [32*NS-1:0]  a_mdata, r_mdata;
   logic [4*NS-1:0]   a_be, r_be;
   logic [15:0]       a_unm, a_tmo, r_unm, r_tmo;

   ctrlport_window_router #(.NUM_SLAVES(NS), .RELATIVE_ADDR(1'b0), .TIMEOUT(TMO)) u_abs (
      .ctrlport_clk           (clk),
      .ctrlport_rst           (rst),
      .s_ctrlport_req_wr      (req_wr),
      .s_ctrlport_req_rd      (req_rd),
      .s_ctrlport_req_addr    (req_addr),
      .s_ctrlport_req_data    (req_data),
      .s_ctrlport_req_byte_en (req_be),
      .s_ctrlport_resp_ack    (a_ack),
      .s_ctrlport_resp_status (a_status),
      .s_ctrlport_resp_data   (a_data),
      .m_ctrlport_req_wr      (a_wr),
      .m_ctrlport_req_rd      (a_rd),
      .m_ctrlport_req_addr    (a_addr),
      .m_ctrlport_req_data    (a_mdata),
      .m_ctrlport_req_byte_en (a_be),
      .m_ctrlport_resp_ack    (sl_ack),
      .m_ctrlport_resp_status (sl_status),
      .m_ctrlport_resp_data   (sl_data),
      .unmapped_count         (a_unm),
      .timeout_count          (a_tmo)
   );

   ctrlport_window_router #(.NUM_SLAVES(NS), .RELATIVE_ADDR(1'b1), .TIMEOUT(TMO)) u_rel (
      .ctrlport_clk           (clk),
      .ctrlport_rst           (rst),
      .s_ctrlport_req_wr      (req_wr),
      .s_ctrlport_req_rd      (req_rd),
      .s_ctrlport_req_addr    (req_addr),
      .s_ctrlport_req_data    (req_data),
      .s_ctrlport_req_byte_en (req_be),
      .s_ctrlport_resp_ack    (r_ack),
      .s_ctrlport_resp_status (r_status),
      .s_ctrlport_resp_data   (r_data),
      .m_ctrlport_req_wr      (r_wr),
      .m_ctrlport_req_rd      (r_rd),
      .m_ctrlport_req_addr    (r_addr),
      .m_ctrlport_req_data    (r_mdata),
      .m_ctrlport_req_byte_en (r_be),
      .m_ctrlport_resp_ack    (sl_ack),
      .m_ctrlport_resp_status (sl_status),
      .m_ctrlport_resp_data   (sl_data),
      .unmapped_count         (r_unm),
      .timeout_count          (r_tmo)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        ack_now;
   logic [33:0] exp_q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample at the falling edge, score any upstream ack
   task automatic step();
      logic [33:0] e;
      @(posedge clk);
      @(negedge clk);
      ack_now = a_ack;
      if (a_ack || r_ack) begin
         check("ack_agree", 128'(r_ack), 128'(a_ack));
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 128'(a_ack | r_ack), 128'(0));
         end else begin
            e = exp_q.pop_front();
            check("resp_abs", 128'({a_status, a_data}), 128'(e));
            check("resp_rel", 128'({r_status, r_data}), 128'(e));
         end
      end
   endtask

   task automatic send(input logic wr, input logic rd, input logic [19:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
      req_wr = wr; req_rd = rd; req_addr = addr; req_data = data; req_be = be;
      step();
      req_wr = 1'b0; req_rd = 1'b0;
   endtask

   task automatic slave_ack(input int idx, input logic [1:0] st, input logic [31:0] d);
      sl_ack                 = '0;
      sl_ack[idx]            = 1'b1;
      sl_status[2*idx +: 2]  = st;
      sl_data[32*idx +: 32]  = d;
   endtask

   task automatic chk_strobe(input string tag, input logic [NS-1:0] wr, input logic [NS-1:0] rd);
      check({tag, "_wr"}, 128'({a_wr, r_wr}), 128'({wr, wr}));
      check({tag, "_rd"}, 128'({a_rd, r_rd}), 128'({rd, rd}));
   endtask

   initial begin
      rst = 1'b1;
      req_wr = 1'b0; req_rd = 1'b1; req_addr = 20'h00C04; req_data = '0; req_be = 4'hF;
      sl_ack = '0; sl_status = '0; sl_data = '0;
      ack_now = 1'b0;

      // Reset with a request held high: nothing may come out
      repeat (3) step();
      req_rd = 1'b0;
      check("rst_resp", 128'({a_ack, a_status, a_data, r_ack, r_status, r_data}), 128'(0));
      check("rst_req", 128'({a_wr, a_rd, r_wr, r_rd, a_be, r_be}), 128'(0));
      check("rst_cnt", 128'({a_unm, a_tmo, r_unm, r_tmo}), 128'(0));
      rst = 1'b0;
      step();
      chk_strobe("post_rst", '0, '0);

      // Read slave 1; slave acks two cycles after its strobe
      send(1'b0, 1'b1, 20'h00C04, 32'h0, 4'hF);
      chk_strobe("t1_capture", '0, '0);
      step();
      chk_strobe("t1_strobe", '0, 4'b0010);
      check("t1_addr_abs", 128'(a_addr[20 +: 20]), 128'(20'h00C04));
      check("t1_addr_rel", 128'(r_addr[20 +: 20]), 128'(20'h00004));
      step();
      chk_strobe("t1_one_pulse", '0, '0);
      step();
      slave_ack(1, 2'd0, 32'hCAFE0001);
      exp_q.push_back({2'd0, 32'hCAFE0001});
      step();
      sl_ack = '0;
      check("t1_ack_timing", 128'(ack_now), 128'(1));
      step();
      check("t1_ack_pulse", 128'(ack_now), 128'(0));

      // Write slave 3; slave acks in its strobe cycle (3-cycle latency)
      send(1'b1, 1'b0, 20'h02010, 32'h0000005A, 4'hF);
      step();
      chk_strobe("t2_strobe", 4'b1000, '0);
      check("t2_addr_abs", 128'(a_addr[60 +: 20]), 128'(20'h02010));
      check("t2_addr_rel", 128'(r_addr[60 +: 20]), 128'(20'h00010));
      check("t2_data", 128'({a_mdata[96 +: 32], r_mdata[96 +: 32]}), 128'({32'h5A, 32'h5A}));
      check("t2_be", 128'({a_be[12 +: 4], r_be[12 +: 4]}), 128'(8'hFF));
      slave_ack(3, 2'd3, 32'h12345678);
      exp_q.push_back({2'd3, 32'h12345678});
      step();
      sl_ack = '0;
      check("t2_latency", 128'(ack_now), 128'(1));

      // Unmapped read: CMDERR one cycle later
      exp_q.push_back({2'd1, 32'h0});
      send(1'b0, 1'b1, 20'h03000, 32'h0, 4'hF);
      check("t3_ack_1cycle", 128'(ack_now), 128'(1));
      step();
      chk_strobe("t3_no_strobe", '0, '0);
      check("t3_unmapped", 128'({a_unm, r_unm}), 128'({16'd1, 16'd1}));

      // Slave 0 never acks: timeout; busy request and foreign ack ignored
      send(1'b0, 1'b1, 20'h00004, 32'h0, 4'hF);
      step();
      chk_strobe("t4_strobe", '0, 4'b0001);
      req_wr = 1'b1; req_addr = 20'h00C08;
      step();
      req_wr = 1'b0;
      slave_ack(1, 2'd0, 32'hDEAD0000);
      step();
      sl_ack = '0;
      chk_strobe("t4_busy_drop", '0, '0);
      repeat (4) step();
      check("t4_no_early", 128'(ack_now), 128'(0));
      exp_q.push_back({2'd1, 32'h0});
      step();
      check("t4_timeout_ack", 128'(ack_now), 128'(1));
      check("t4_tmo_count", 128'({a_tmo, r_tmo}), 128'({16'd1, 16'd1}));
      slave_ack(0, 2'd0, 32'h0BAD0000);
      step();
      sl_ack = '0;
      step();
      check("t4_late_ack", 128'(ack_now), 128'(0));

      // Slave 2 ack on the expiry cycle wins over the timeout
      send(1'b0, 1'b1, 20'h01008, 32'h0, 4'hF);
      repeat (7) step();
      slave_ack(2, 2'd0, 32'hA5A50002);
      exp_q.push_back({2'd0, 32'hA5A50002});
      step();
      sl_ack = '0;
      check("t5_ack", 128'(ack_now), 128'(1));
      check("t5_tmo_same", 128'({a_tmo, r_tmo}), 128'({16'd1, 16'd1}));

      // wr and rd together: CMDERR
      exp_q.push_back({2'd1, 32'h0});
      send(1'b1, 1'b1, 20'h00C00, 32'h1, 4'hF);
      check("t6_ack", 128'(ack_now), 128'(1));
      step();
      chk_strobe("t6_no_strobe", '0, '0);
      check("t6_unmapped", 128'({a_unm, r_unm}), 128'({16'd2, 16'd2}));

      // Reset mid-WAIT, then a late slave ack: no response
      send(1'b0, 1'b1, 20'h01004, 32'h0, 4'hF);
      step();
      chk_strobe("t7_strobe", '0, 4'b0100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t7_cnt_clear", 128'({a_unm, a_tmo, r_unm, r_tmo}), 128'(0));
      slave_ack(2, 2'd0, 32'h77777777);
      step();
      sl_ack = '0;
      step();
      check("t7_no_ack", 128'(ack_now), 128'(0));
      send(1'b0, 1'b1, 20'h00C10, 32'h0, 4'hF);
      step();
      chk_strobe("t7_next_strobe", '0, 4'b0010);
      slave_ack(1, 2'd0, 32'h0BADF00D);
      exp_q.push_back({2'd0, 32'h0BADF00D});
      step();
      sl_ack = '0;
      check("t7_next_ack", 128'(ack_now), 128'(1));

      // Hold an unmapped read to drive unmapped_count into saturation
      req_rd = 1'b1; req_addr = 20'h03000;
      for (int k = 1; k <= 65538; k++) begin
         exp_q.push_back({2'd1, 32'h0});
         step();
         step();
         if (k == 65534) check("sat_pre", 128'({a_unm, r_unm}), 128'({16'hFFFE, 16'hFFFE}));
         if (k == 65535) check("sat_hit", 128'({a_unm, r_unm}), 128'({16'hFFFF, 16'hFFFF}));
      end
      req_rd = 1'b0;
      check("sat_hold", 128'({a_unm, r_unm}), 128'({16'hFFFF, 16'hFFFF}));
      step();
      check("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
